// File: rtl/sys_bus_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and system memory.
interface sys_bus_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  // Instruction-cache requester
  logic          ic_req;
  logic          ic_rw;
  logic [AW-1:0] ic_addr;
  logic [DW-1:0] ic_wdata;
  logic          ic_ack;
  // Data-cache requester
  logic          dc_req;
  logic          dc_rw;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic          dc_ack;
  // Shared read data and memory port
  logic [DW-1:0] rdata;
  logic          mem_strobe;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_oe;
  logic [DW-1:0] mem_rdata;
  // Status
  logic          gnt_dc;
  logic          busy;

  // Arbiter side
  modport slave (
    input  ic_req, ic_rw, ic_addr, ic_wdata,
    input  dc_req, dc_rw, dc_addr, dc_wdata,
    input  mem_rdata,
    output ic_ack, dc_ack, rdata,
    output mem_strobe, mem_rw, mem_addr, mem_wdata, mem_oe,
    output gnt_dc, busy
  );

  // Requester / memory side
  modport master (
    output ic_req, ic_rw, ic_addr, ic_wdata,
    output dc_req, dc_rw, dc_addr, dc_wdata,
    output mem_rdata,
    input  ic_ack, dc_ack, rdata,
    input  mem_strobe, mem_rw, mem_addr, mem_wdata, mem_oe,
    input  gnt_dc, busy
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one system-memory port between the IC and DC
// controllers. Grant in IDLE, one-cycle strobe in ISSUE, WAIT_CYCLES wait
// states, then a one-cycle ack to the owner in DONE.
module sys_bus_arbiter #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input logic             clk,
  input logic             reset,
  sys_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_dc_q, last_dc_d;
  logic          gnt_dc_q, gnt_dc_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          grant_dc;

  // State and datapath registers; reset leaves the DC as last owner so IC wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      last_dc_q <= 1'b1;
      gnt_dc_q  <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_dc_q <= last_dc_d;
      gnt_dc_q  <= gnt_dc_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic: arbitration, wait-state counting and read-data capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_dc_d = last_dc_q;
    gnt_dc_d  = gnt_dc_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    // On a tie the requester that did not own the bus last wins.
    grant_dc  = bus.dc_req && (!bus.ic_req || !last_dc_q);

    case (state_q)
      StIdle: begin
        if (bus.ic_req || bus.dc_req) begin
          gnt_dc_d = grant_dc;
          rw_d     = grant_dc ? bus.dc_rw    : bus.ic_rw;
          addr_d   = grant_dc ? bus.dc_addr  : bus.ic_addr;
          wdata_d  = grant_dc ? bus.dc_wdata : bus.ic_wdata;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = WaitCnt;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        // Memory data is valid in the last wait cycle only.
        if (cnt_q == 4'd1) begin
          if (rw_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        last_dc_d = gnt_dc_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state, so an asynchronous reset clears them at once.
  assign bus.busy       = (state_q != StIdle);
  assign bus.mem_strobe = (state_q == StIssue);
  assign bus.mem_oe     = (state_q != StIdle) && !rw_q;
  assign bus.ic_ack     = (state_q == StDone) && !gnt_dc_q;
  assign bus.dc_ack     = (state_q == StDone) && gnt_dc_q;
  assign bus.gnt_dc     = gnt_dc_q;
  assign bus.mem_rw     = rw_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: directed scenarios plus a random
// phase, compared every cycle against a transaction-timeline model.
module tb_sys_bus_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          W  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sys_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sys_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: m_n counts cycles since the grant (0 = idle, 1 = strobe, W+2 = ack).
  int            m_n;
  bit            m_own, m_last_dc, m_gnt, m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  bit            hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_own = 0; m_last_dc = 1; m_gnt = 0; m_rw = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic model_advance();
    if (m_n == 0) begin
      if (bus.ic_req || bus.dc_req) begin
        m_own   = (bus.ic_req && bus.dc_req) ? !m_last_dc : bus.dc_req;
        m_gnt   = m_own;
        m_rw    = m_own ? bus.dc_rw : bus.ic_rw;
        m_addr  = m_own ? bus.dc_addr : bus.ic_addr;
        m_wdata = m_own ? bus.dc_wdata : bus.ic_wdata;
        m_n     = 1;
      end
    end else if (m_n == W + 1) begin
      if (m_rw) m_rdata = bus.mem_rdata;
      m_n++;
    end else if (m_n == W + 2) begin
      m_last_dc = m_own;
      m_n = 0;
    end else begin
      m_n++;
    end
  endtask

  task automatic check_all();
    chk("busy", bus.busy, m_n > 0);
    chk("mem_strobe", bus.mem_strobe, m_n == 1);
    chk("ic_ack", bus.ic_ack, (m_n == W + 2) && !m_own);
    chk("dc_ack", bus.dc_ack, (m_n == W + 2) && m_own);
    chk("mem_oe", bus.mem_oe, (m_n > 0) && !m_rw);
    chk("gnt_dc", bus.gnt_dc, m_gnt);
    chk("mem_rw", bus.mem_rw, m_rw);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("rdata", bus.rdata, m_rdata);
  endtask

  // One clock: advance the model on the current inputs, then check at the falling edge.
  task automatic step();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (!hold) begin
      if (bus.ic_ack) bus.ic_req = 1'b0;
      if (bus.dc_ack) bus.dc_req = 1'b0;
    end
  endtask

  logic [31:0] m_strobe, m_ic, m_dc, m_oe;
  logic [5:0]  order;
  int          n_grants;

  initial begin
    bus.ic_req = 0; bus.ic_rw = 0; bus.ic_addr = '0; bus.ic_wdata = '0;
    bus.dc_req = 0; bus.dc_rw = 0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.mem_rdata = '0;
    hold = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;
    @(negedge clk);
    check_all();

    // Single IC read
    bus.ic_req = 1; bus.ic_rw = 1; bus.ic_addr = 32'h100; bus.mem_rdata = 32'hDEADBEEF;
    m_strobe = 0; m_ic = 0; m_dc = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (bus.mem_strobe) m_strobe[c] = 1'b1;
      if (bus.ic_ack) m_ic[c] = 1'b1;
      if (bus.dc_ack) m_dc[c] = 1'b1;
    end
    chk("t1_strobe_cycles", m_strobe, 32'h2);
    chk("t1_ic_ack_cycles", m_ic, 32'h40);
    chk("t1_dc_ack_never", m_dc, 32'h0);
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);

    // DC write
    bus.dc_req = 1; bus.dc_rw = 0; bus.dc_addr = 32'h200; bus.dc_wdata = 32'h12345678;
    m_oe = 0; m_dc = 0;
    for (int c = 1; c <= 8; c++) begin
      bus.mem_rdata = $urandom;
      step();
      if (bus.mem_oe) m_oe[c] = 1'b1;
      if (bus.dc_ack) m_dc[c] = 1'b1;
      if (c == 1) begin
        chk("t2_mem_rw", bus.mem_rw, 1'b0);
        chk("t2_mem_addr", bus.mem_addr, 32'h200);
        chk("t2_mem_wdata", bus.mem_wdata, 32'h12345678);
      end
    end
    chk("t2_oe_cycles", m_oe, 32'h7E);
    chk("t2_dc_ack_cycles", m_dc, 32'h40);
    chk("t2_rdata_kept", bus.rdata, 32'hDEADBEEF);

    // Simultaneous requests right after reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check_all();
    bus.ic_req = 1; bus.ic_rw = 1; bus.ic_addr = 32'h140;
    bus.dc_req = 1; bus.dc_rw = 1; bus.dc_addr = 32'h240;
    m_ic = 0; m_dc = 0;
    for (int c = 1; c <= 15; c++) begin
      bus.mem_rdata = $urandom;
      step();
      if (bus.ic_ack) m_ic[c] = 1'b1;
      if (bus.dc_ack) m_dc[c] = 1'b1;
    end
    chk("t3_ic_ack_cycles", m_ic, 32'h40);
    chk("t3_dc_ack_cycles", m_dc, 32'h2000);

    // Both held high: six strictly alternating grants
    hold = 1;
    bus.ic_req = 1; bus.dc_req = 1;
    order = 0; n_grants = 0;
    for (int c = 1; c <= 6 * (W + 3) - 1; c++) begin
      bus.mem_rdata = $urandom;
      step();
      if (bus.mem_strobe) begin
        order = {order[4:0], bus.gnt_dc};
        n_grants++;
      end
    end
    bus.ic_req = 0; bus.dc_req = 0;
    hold = 0;
    repeat (2) step();
    chk("t4_grant_count", n_grants, 6);
    chk("t4_grant_order", order, 6'b010101);

    // Drop req and change address during WAIT
    bus.ic_req = 1; bus.ic_rw = 1; bus.ic_addr = 32'h300;
    m_ic = 0;
    for (int c = 1; c <= 8; c++) begin
      bus.mem_rdata = $urandom;
      step();
      if (bus.ic_ack) m_ic[c] = 1'b1;
      if (c == 3) begin
        bus.ic_req = 0;
        bus.ic_addr = 32'hABC;
      end
      if (c == 5) chk("t5_mem_addr_latched", bus.mem_addr, 32'h300);
    end
    chk("t5_ack_after_drop", m_ic, 32'h40);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (!bus.ic_req && $urandom_range(0, 2) == 0) begin
        bus.ic_req = 1; bus.ic_rw = 1'($urandom); bus.ic_addr = $urandom; bus.ic_wdata = $urandom;
      end else if (bus.ic_req && $urandom_range(0, 5) == 0) begin
        bus.ic_addr = $urandom;
      end
      if (!bus.dc_req && $urandom_range(0, 2) == 0) begin
        bus.dc_req = 1; bus.dc_rw = 1'($urandom); bus.dc_addr = $urandom; bus.dc_wdata = $urandom;
      end else if (bus.dc_req && $urandom_range(0, 5) == 0) begin
        bus.dc_wdata = $urandom;
      end
      bus.mem_rdata = $urandom;
      step();
    end
    for (int i = 0; i < 40 && (bus.ic_req || bus.dc_req || m_n != 0); i++) begin
      step();
    end
    chk("drain_idle", {bus.busy, bus.ic_req, bus.dc_req}, 3'b000);

    // Asynchronous reset during WAIT of a write
    bus.ic_req = 1; bus.ic_rw = 0; bus.ic_addr = 32'h400; bus.ic_wdata = 32'h5A5A5A5A;
    repeat (3) step();
    chk("t6_in_wait_oe", bus.mem_oe, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_busy_async", bus.busy, 1'b0);
    chk("t6_oe_async", bus.mem_oe, 1'b0);
    chk("t6_acks_async", {bus.ic_ack, bus.dc_ack}, 2'b00);
    chk("t6_addr_async", bus.mem_addr, 32'h0);
    bus.ic_req = 0;
    @(negedge clk);
    model_reset();
    check_all();
    reset = 1'b1;
    bus.ic_req = 1; bus.ic_rw = 1; bus.ic_addr = 32'h500;
    bus.dc_req = 1; bus.dc_rw = 1; bus.dc_addr = 32'h600;
    m_ic = 0; m_dc = 0;
    for (int c = 1; c <= 15; c++) begin
      bus.mem_rdata = $urandom;
      step();
      if (c == 1) chk("t6_ic_first", bus.gnt_dc, 1'b0);
      if (bus.ic_ack) m_ic[c] = 1'b1;
      if (bus.dc_ack) m_dc[c] = 1'b1;
    end
    chk("t6_ic_ack_cycles", m_ic, 32'h40);
    chk("t6_dc_ack_cycles", m_dc, 32'h2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Shares the single system-memory port between the instruction-cache controller (IC) and the data-cache controller (DC) of the pipelined CPU.
- Each controller raises a request. The arbiter grants one requester round-robin, then drives the memory strobe, address, direction and write data.
- It counts memory wait states internally, captures read data, and returns a one-cycle acknowledge to the granted requester.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_CYCLES, 4, memory wait states per access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ic_req  in  1  IC request; held high until ic_ack.
- ic_rw  in  1  IC direction; 1 = read, 0 = write.
- ic_addr  in  AW  IC address.
- ic_wdata  in  DW  IC write data.
- ic_ack  out  1  one-cycle completion pulse to IC.
- dc_req  in  1  DC request; held high until dc_ack.
- dc_rw  in  1  DC direction; 1 = read, 0 = write.
- dc_addr  in  AW  DC address.
- dc_wdata  in  DW  DC write data.
- dc_ack  out  1  one-cycle completion pulse to DC.
- rdata  out  DW  registered read data, shared by both requesters; valid while the ack is high.
- mem_strobe  out  1  one-cycle access start to memory.
- mem_rw  out  1  memory direction, latched at grant.
- mem_addr  out  AW  memory address, latched at grant.
- mem_wdata  out  DW  memory write data, latched at grant.
- mem_oe  out  1  write-data drive enable.
- mem_rdata  in  DW  memory read data; valid in the last WAIT cycle.
- gnt_dc  out  1  current or last owner; 1 = DC, 0 = IC.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, counter = 0, last_owner = DC (so IC wins the first tie).
  - All outputs 0, including rdata, mem_addr and mem_wdata.
- States and encoding: IDLE = 0, ISSUE = 1, WAIT = 2, DONE = 3.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not last_owner.
  - On grant: latch owner, rw, addr and wdata into the mem_* registers, set gnt_dc, go to ISSUE.
- ISSUE:
  - mem_strobe = 1 for this cycle only.
  - mem_oe = 1 if the access is a write.
  - Load counter = WAIT_CYCLES, go to WAIT.
- WAIT:
  - mem_oe stays 1 for writes.
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1: capture mem_rdata into rdata if the access is a read, then go to DONE.
- DONE:
  - Pulse the owner's ack for one cycle; mem_oe stays 1 for writes.
  - Set last_owner = owner, go to IDLE.
- Latency:
  - Request first seen high in IDLE at cycle 0 → ISSUE at cycle 1, WAIT at cycles 2..WAIT_CYCLES+1, ack at cycle WAIT_CYCLES+2.
  - Back-to-back grants are separated by one IDLE cycle.
- Handshake:
  - Requesters drop req on the clock edge after ack; the IDLE cycle after DONE therefore sees the updated request.
  - A req still high in that IDLE cycle is treated as a new request.
  - Dropping req mid-transaction does not abort: the access completes and ack is still pulsed.
  - A requester's address, data and rw changes after grant are ignored because they are latched.
- Fairness: with both requesters held continuously high, grants strictly alternate.
- rdata:
  - Holds its value until the next read capture.
  - Writes leave rdata unchanged.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no ack is issued for the aborted access.
- gnt_dc holds its last value through IDLE; only a new grant changes it.
- Counter width: 4 bits.

Test Plan:
- Reset then single IC read: ic_req = 1, ic_addr = 0x100, WAIT_CYCLES = 4, mem_rdata = 0xDEADBEEF during WAIT → mem_strobe high in cycle 1 only; ic_ack high in cycle 6 only; rdata = 0xDEADBEEF; dc_ack never asserts.
- DC write: dc_req = 1, dc_rw = 0, dc_addr = 0x200, dc_wdata = 0x12345678 → mem_rw = 0, mem_addr = 0x200, mem_wdata = 0x12345678; mem_oe high cycles 1..6; dc_ack in cycle 6; rdata unchanged.
- Simultaneous requests immediately after reset → IC granted first; DC granted in the IDLE cycle after ic_ack; dc_ack in cycle 13.
- Both requests held high for 6 transactions → grant order IC, DC, IC, DC, IC, DC; each ack is a single cycle.
- Requester drops req during WAIT → transaction completes and ack is still pulsed at cycle WAIT_CYCLES+2; a change to ic_addr after grant does not alter mem_addr.
- reset asserted low during WAIT, asynchronously mid-cycle → busy, mem_oe and both acks 0 immediately; after release, IC retains first-tie priority and a new request completes normally.
